// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle for the multi-port register file
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int AW = $clog2(DEPTH)
);
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic wr0_en;
  logic [AW-1:0] wr0_addr;
  logic [WIDTH-1:0] wr0_data;
  logic wr1_en;
  logic [AW-1:0] wr1_addr;
  logic [WIDTH-1:0] wr1_data;
  logic ready;
  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input rd_data, ready
  );
  modport slave (
    input rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_data, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, two prioritised write ports, optional zero register and bypass, post-reset scrub
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  regfile_mp_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;
  logic ready, ready_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic we0, we1;
  logic [AW-1:0] a;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      ready <= ready_nxt;
    end
  always_comb begin
    state_nxt = state;
    clr_ptr_nxt = clr_ptr;
    ready_nxt = ready;
    if (state == CLEAR) begin
      clr_ptr_nxt = clr_ptr + 1'b1;
      state_nxt = clr_ptr == AW'(DEPTH - 1) ? RUN : CLEAR;
      ready_nxt = clr_ptr == AW'(DEPTH - 1);
    end
  end
  // wr1 wins an address collision, so wr0 stands down rather than relying on NBA ordering
  assign we1 = bus.wr1_en && state == RUN && !(ZERO_REG != 0 && bus.wr1_addr == '0);
  assign we0 = bus.wr0_en && state == RUN && !(ZERO_REG != 0 && bus.wr0_addr == '0)
               && !(bus.wr1_en && bus.wr1_addr == bus.wr0_addr);
  always_ff @(posedge clk)
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      if (we0) mem[bus.wr0_addr] <= bus.wr0_data;
      if (we1) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  always_comb begin
    a = '0;
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      bus.rd_data[k*WIDTH +: WIDTH] =
        state == CLEAR || (ZERO_REG != 0 && a == '0) ? '0 :
        BYPASS != 0 && bus.wr1_en && bus.wr1_addr == a ? bus.wr1_data :
        BYPASS != 0 && bus.wr0_en && bus.wr0_addr == a ? bus.wr0_data :
        mem[a];
    end
  end
  assign bus.ready = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, one bypassing and one non-bypassing instance
module tb_regfile_mp;
  localparam int W = 32;
  localparam int D = 32;
  localparam int N = 2;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  typedef struct {
    string tag;
    bit d;
    int p;
    logic [W-1:0] v;
  } exp_t;
  exp_t sb[$];
  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(N)) ia ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(N)) ib ();
  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(N), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(N), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic push(input string tag, input bit d, input int p, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag;
    e.d = d;
    e.p = p;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.d ? ib.rd_data[e.p*W +: W] : ia.rd_data[e.p*W +: W], e.v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ia.wr0_en = 1'b0;
    ia.wr1_en = 1'b0;
    ib.wr0_en = 1'b0;
    ib.wr1_en = 1'b0;
  endtask
  task automatic rd(input int a0, input int a1);
    ia.rd_addr = {AW'(a1), AW'(a0)};
    ib.rd_addr = {AW'(a1), AW'(a0)};
  endtask
  task automatic wa(input int port, input int addr, input logic [W-1:0] data);
    if (port == 0) begin
      ia.wr0_en = 1'b1;
      ia.wr0_addr = AW'(addr);
      ia.wr0_data = data;
    end else begin
      ia.wr1_en = 1'b1;
      ia.wr1_addr = AW'(addr);
      ia.wr1_data = data;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
  initial begin
    idle();
    ia.wr0_addr = '0; ia.wr0_data = '0; ia.wr1_addr = '0; ia.wr1_data = '0;
    ib.wr0_addr = '0; ib.wr0_data = '0; ib.wr1_addr = '0; ib.wr1_data = '0;
    rd(3, 17);
    step();
    step();
    chk("rst_ready_a", 32'(ia.ready), 0);
    chk("rst_ready_b", 32'(ib.ready), 0);
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      push($sformatf("scrub_rd0_e%0d", e), 0, 0, 0);
      push($sformatf("scrub_rd1_e%0d", e), 0, 1, 0);
      drain();
      chk($sformatf("scrub_ready_e%0d", e), 32'(ia.ready), 32'(e == 32));
    end
    chk("scrub_ready_b", 32'(ib.ready), 1);
    wa(0, 5, 32'hDEADBEEF);
    wa(1, 9, 32'h12345678);
    step();
    idle();
    rd(5, 9);
    push("dual_r5", 0, 0, 32'hDEADBEEF);
    push("dual_r9", 0, 1, 32'h12345678);
    drain();
    wa(0, 7, 32'hAAAA0000);
    wa(1, 7, 32'h0000BBBB);
    rd(7, 7);
    push("conf_byp0", 0, 0, 32'h0000BBBB);
    push("conf_byp1", 0, 1, 32'h0000BBBB);
    drain();
    step();
    idle();
    push("conf_r7", 0, 0, 32'h0000BBBB);
    drain();
    wa(0, 0, 32'hFFFFFFFF);
    wa(1, 0, 32'hFFFFFFFF);
    rd(0, 0);
    push("zero_byp0", 0, 0, 0);
    push("zero_byp1", 0, 1, 0);
    drain();
    step();
    idle();
    push("zero_rd0", 0, 0, 0);
    push("zero_rd1", 0, 1, 0);
    drain();
    ib.wr0_en = 1'b1; ib.wr0_addr = 5'd3; ib.wr0_data = 32'h11;
    step();
    idle();
    ib.wr0_en = 1'b1; ib.wr0_data = 32'h22;
    wa(0, 3, 32'h22);
    rd(3, 3);
    push("nobyp_same", 1, 0, 32'h11);
    push("byp_same", 0, 1, 32'h22);
    drain();
    step();
    idle();
    push("nobyp_next", 1, 1, 32'h22);
    drain();
    for (int i = 1; i <= 31; i += 2) begin
      wa(0, i, 32'h1000_0000 | 32'(i));
      if (i < 31) wa(1, i + 1, 32'h2000_0000 | 32'(i + 1));
      step();
      idle();
    end
    rd(31, 2);
    push("fill_r31", 0, 0, 32'h1000_001F);
    push("fill_r2", 0, 1, 32'h2000_0002);
    drain();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("mid_scrub_ready_e%0d", e), 32'(ia.ready), 0);
    end
    rst = 1'b1;
    wa(0, 4, 32'hBAD0_0000);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      wa(0, e % 32, 32'hBAD0_0000 | 32'(e));
      wa(1, (e + 5) % 32, 32'hBAD1_0000 | 32'(e));
      step();
      chk($sformatf("rescrub_ready_e%0d", e), 32'(ia.ready), 32'(e == 32));
    end
    idle();
    for (int i = 1; i <= 31; i += 2) begin
      rd(i, i < 31 ? i + 1 : 0);
      push($sformatf("clr_r%0d", i), 0, 0, 0);
      push($sformatf("clr_r%0d", i < 31 ? i + 1 : 0), 0, 1, 0);
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
